adder32: RTL and testbench



---
 rtl/adder32.sv | 109 ++++++++++
 tb/tb_adder32.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/adder32.sv
// Two-level carry-lookahead adder with combinational sum/carry/overflow
// and a one-stage registered copy of the same results.

module adder32_cla4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:1] c,
  output logic       gg,
  output logic       gp
);

  always_comb begin
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
  end

endmodule

module adder32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] y_q,
  output logic             cout_q,
  output logic             ovf_q
);

  localparam int unsigned NG = WIDTH / 4;
  localparam int unsigned SB = (NG > 8) ? 8 : NG;
  localparam int unsigned NS = (NG + SB - 1) / SB;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      gc;
  logic             carry;
  logic             term;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    assign c[4*j] = gc[j];
    adder32_cla4 u_cla4 (
      .g   (g[4*j+3 -: 4]),
      .p   (p[4*j+3 -: 4]),
      .cin (gc[j]),
      .c   (c[4*j+3 : 4*j+1]),
      .gg  (grp_g[j]),
      .gp  (grp_p[j])
    );
  end

  // Flat sum-of-products lookahead inside each super-block of up to 8 groups;
  // super-blocks chain through their top carry (gc at the block base).
  always_comb begin
    gc    = '0;
    carry = 1'b0;
    term  = 1'b0;
    for (int unsigned s = 0; s < NS; s++) begin
      for (int unsigned j = s*SB + 1; (j <= s*SB + SB) && (j <= NG); j++) begin
        carry = 1'b0;
        for (int unsigned k = s*SB; k < j; k++) begin
          term = grp_g[k];
          for (int unsigned m = k + 1; m < j; m++) begin
            term = term & grp_p[m];
          end
          carry = carry | term;
        end
        term = gc[s*SB];
        for (int unsigned m = s*SB; m < j; m++) begin
          term = term & grp_p[m];
        end
        gc[j] = carry | term;
      end
    end
  end

  assign y    = p ^ c;
  assign cout = gc[NG];
  assign ovf  = c[WIDTH-1] ^ gc[NG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      y_q    <= y;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_adder32.sv
// Directed-vector and registered-path checks for adder32.

module tb_adder32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic        cout;
  logic        ovf;
  logic [31:0] y_q;
  logic        cout_q;
  logic        ovf_q;

  int unsigned errors;
  int unsigned checks;

  adder32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .y      (y),
    .cout   (cout),
    .ovf    (ovf),
    .y_q    (y_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [32:0] sum;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        exp_ovf;

    errors = 0;
    checks = 0;

    vecs[0]  = '{"zero",        32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{"uwrap",       32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{"sovf_pos",    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[3]  = '{"sovf_neg",    32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    vecs[4]  = '{"grp_chain",   32'h0FFFFFFF, 32'h00000001, 32'h10000000, 1'b0, 1'b0};
    vecs[5]  = '{"mixed",       32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0};
    vecs[6]  = '{"neg_neg",     32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[7]  = '{"grp0_out",    32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0};
    vecs[8]  = '{"grp5_out",    32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0, 1'b0};
    vecs[9]  = '{"min_plus_m1", 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[10] = '{"full_prop",   32'h0000FFFF, 32'hFFFF0001, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{"all_p",       32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0};

    // Reset state with combinational path live during reset.
    rst = 1'b1;
    a   = 32'd5;
    b   = 32'd7;
    #1;
    check("rst_y_q", y_q, 32'h0);
    check("rst_cout_q", {31'b0, cout_q}, 32'h0);
    check("rst_ovf_q", {31'b0, ovf_q}, 32'h0);
    check("rst_y_live", y, 32'd12);

    for (int i = 0; i < 12; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      #1;
      check({vecs[i].name, "_y"}, y, vecs[i].y);
      check({vecs[i].name, "_cout"}, {31'b0, cout}, {31'b0, vecs[i].cout});
      check({vecs[i].name, "_ovf"}, {31'b0, ovf}, {31'b0, vecs[i].ovf});
      #9;
    end

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      a  = ra;
      b  = rb;
      sum = {1'b0, ra} + {1'b0, rb};
      exp_ovf = (ra[31] == rb[31]) && (sum[31] != ra[31]);
      #1;
      check("rand_y", y, sum[31:0]);
      check("rand_cout", {31'b0, cout}, {31'b0, sum[32]});
      check("rand_ovf", {31'b0, ovf}, {31'b0, exp_ovf});
      #99;
    end

    // Registered path: first capture only after release.
    @(negedge clk);
    a = 32'd5;
    b = 32'd7;
    #1;
    check("held_y_q", y_q, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("cap_y_q", y_q, 32'd12);
    check("cap_cout_q", {31'b0, cout_q}, 32'h0);

    @(negedge clk);
    a = 32'h7FFFFFFF;
    b = 32'h00000001;
    #1;
    check("lat_y_q_hold", y_q, 32'd12);
    @(posedge clk);
    #1;
    check("lat_y_q", y_q, 32'h80000000);
    check("lat_ovf_q", {31'b0, ovf_q}, 32'h1);
    check("lat_cout_q", {31'b0, cout_q}, 32'h0);

    @(negedge clk);
    a = 32'hFFFFFFFF;
    b = 32'h00000001;
    @(posedge clk);
    #1;
    check("wrap_y_q", y_q, 32'h0);
    check("wrap_cout_q", {31'b0, cout_q}, 32'h1);
    check("wrap_ovf_q", {31'b0, ovf_q}, 32'h0);

    @(negedge clk);
    a = 32'd5;
    b = 32'd7;
    @(posedge clk);
    #1;
    check("pre_rst_y_q", y_q, 32'd12);

    // Mid-cycle asynchronous reset.
    #2;
    rst = 1'b1;
    #1;
    check("async_y_q", y_q, 32'h0);
    check("async_cout_q", {31'b0, cout_q}, 32'h0);
    check("async_ovf_q", {31'b0, ovf_q}, 32'h0);
    check("async_y_live", y, 32'd12);

    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rel_y_q_hold", y_q, 32'h0);
    @(posedge clk);
    #1;
    check("rel_y_q", y_q, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
